trdb_stream_packer: RTL and testbench
=====================================

TRDB_STREAM_PACKER -- requirements
Module: trdb_stream_packer

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the output word width in bits; legal values are 32 and 64.
REQ-002 Parameter PACKET_LEN, default 256, SHALL set the maximum packet payload width in bits; it is a multiple of 8 and at most 2040.
REQ-003 Parameter LEN_W, default clog2(PACKET_LEN)+1, SHALL set the width of the packet length field.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 packet_bits_i  input  PACKET_LEN  SHALL carry the packet payload, LSB first.
REQ-007 packet_len_i  input  LEN_W  SHALL give the payload length in bits (0..PACKET_LEN).
REQ-008 valid_i  input  1  SHALL flag the packet as valid.
REQ-009 grant_o  output  1  SHALL be high in the cycle the packet is consumed.
REQ-010 data_o  output  DATA_W  SHALL carry the output word, stream byte 0 in bits [7:0].
REQ-011 valid_o  output  1  SHALL flag data_o as valid.
REQ-012 ready_i  input  1  SHALL be the downstream ready; a word transfers when valid_o and ready_i are both high.
REQ-013 flush_i  input  1  SHALL request that all buffered bytes be drained.
REQ-014 flush_done_o  output  1  SHALL pulse high for one cycle when a flush completes.

Function
REQ-015 Each accepted packet SHALL append to the byte stream one header byte, N = ceil(packet_len_i/8), followed by N payload bytes, packet_bits_i[7:0] first.
REQ-016 Payload bits at and above index packet_len_i SHALL be forced to zero in the emitted bytes.
REQ-017 A packet with packet_len_i == 0 SHALL be granted and SHALL emit nothing.
REQ-018 The block SHALL hold the stream in a byte FIFO of depth DATA_W/8 + PACKET_LEN/8 + 1 bytes with a fill counter (fill).
REQ-019 grant_o SHALL be combinational and high iff valid_i is high, the state is IDLE, and free space >= N+1 after counting any pop in the same cycle.
REQ-020 Bytes of a packet granted in cycle T SHALL first be visible on data_o in cycle T+1.
REQ-021 In IDLE, valid_o SHALL be high iff fill >= DATA_W/8, and data_o SHALL show the oldest DATA_W/8 bytes.
REQ-022 While valid_o is high and ready_i is low, data_o SHALL remain stable.
REQ-023 A push and a pop in the same cycle SHALL both take effect, with fill updated by +(N+1) and -(DATA_W/8).
REQ-024 The state machine SHALL have two states, IDLE and FLUSH, with IDLE the reset state.
REQ-025 IDLE -> FLUSH SHALL occur when flush_i is high; a packet granted in that same cycle SHALL be included in the flush.
REQ-026 In FLUSH, grant_o SHALL be low.
REQ-027 In FLUSH with fill >= DATA_W/8, words SHALL be emitted as in IDLE.
REQ-028 In FLUSH with 0 < fill < DATA_W/8, valid_o SHALL be high and data_o SHALL hold the remaining bytes in the low lanes with the upper lanes zero; the pop SHALL set fill to 0.
REQ-029 In FLUSH with fill == 0, flush_done_o SHALL be high for exactly that cycle and the next state SHALL be IDLE.
REQ-030 flush_i asserted while in FLUSH SHALL be ignored.
REQ-031 The stream SHALL be contiguous with no inter-packet padding; words SHALL be partially padded only by a flush.

Reset
REQ-032 While rst_i is high, outputs SHALL be: valid_o=0, data_o=0, grant_o=0, flush_done_o=0.
REQ-033 Reset SHALL set fill=0, empty the FIFO and set the state to IDLE, including reset mid-flush or mid-packet.
REQ-034 Buffered bytes SHALL be discarded by reset and not emitted afterwards.

Verification (DATA_W=32, PACKET_LEN=64)
REQ-035 Reset: hold rst_i=1 with valid_i=1 -> grant_o=0, valid_o=0, data_o=0, flush_done_o=0.
REQ-036 Single packet: len=24, bits=0xCCBBAA, ready_i=1 -> grant_o=1 at T; at T+1, valid_o=1 and data_o=0xCCBBAA03; fill=0 afterwards.
REQ-037 Packing plus flush: packets len=8 bits=0x11, then len=16 bits=0x3322 -> word 0x22021101; then flush_i=1 -> word 0x00000033, then flush_done_o pulses once.
REQ-038 Masking and backpressure: len=4, bits=0xFF -> header 0x01 and payload 0x0F; with ready_i=0 until the FIFO is full -> grant_o=0 and data_o stable; after ready_i=1, the stream resumes with no lost or duplicated bytes.
REQ-039 Reset mid-flush: fill=2, flush_i=1, ready_i=0, then rst_i=1 for 1 cycle -> state IDLE, valid_o=0, no flush_done_o pulse, and no stale bytes in later output.
REQ-040 Zero length: len=0 with valid_i=1 -> grant_o=1, fill unchanged, valid_o unchanged.

Source files
------------

// File: rtl/trdb_stream_packer.sv
// -----------------------------------------------------------------------------
// trdb_stream_packer
//
// Turns variable-length trace packets into a contiguous byte stream and
// serves that stream as fixed-width words. Each accepted packet contributes
// one header byte (the payload byte count N = ceil(len/8)) followed by N
// payload bytes, LSB first. Payload bits at or above the packet length are
// cleared before they enter the stream. Zero-length packets are accepted
// and contribute no bytes.
//
// Storage is a byte FIFO of DEPTH = DATA_W/8 + PACKET_LEN/8 + 1 bytes. The
// FIFO is kept as a flat shift register: byte 0 is always the oldest byte.
// A pop shifts the contents down, and a push appends after the bytes that
// remain once the pop is counted.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset; empties the FIFO and
//                  returns to IDLE; all outputs are forced low while high
//   packet_bits_i  packet payload, LSB first
//   packet_len_i   payload length in bits, 0..PACKET_LEN
//   valid_i        packet on packet_bits_i/packet_len_i is offered
//   grant_o        packet is consumed this cycle (combinational)
//   data_o         output word, oldest stream byte in bits [7:0]
//   valid_o        data_o holds a word
//   ready_i        downstream ready
//   flush_i        request a drain of everything buffered
//   flush_done_o   one-cycle pulse when a drain has finished
//   state_o        debug: 0 = IDLE, 1 = FLUSH
//   fill_o         debug: number of bytes in the FIFO
//
// Handshakes
//   Output word: a word moves when valid_o && ready_i in the same cycle.
//   While valid_o is high and ready_i is low, data_o is held unchanged.
//   Input packet: valid_i offers a packet; it is consumed in the cycle
//   grant_o is high. grant_o depends on valid_i and on this cycle's pop.
// -----------------------------------------------------------------------------
module trdb_stream_packer #(
  parameter int DATA_W     = 32,
  parameter int PACKET_LEN = 256,
  parameter int LEN_W      = $clog2(PACKET_LEN) + 1,
  localparam int LANES     = DATA_W / 8,
  localparam int DEPTH     = DATA_W / 8 + PACKET_LEN / 8 + 1,
  localparam int FILL_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PACKET_LEN-1:0] packet_bits_i,
  input  logic [LEN_W-1:0]      packet_len_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  state_o,
  output logic [FILL_W-1:0]     fill_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q;
  logic [8*DEPTH-1:0]      mem_q, mem_d;

  int                      fill_int;
  int                      n_bytes;
  int                      pop_cnt;
  int                      push_cnt;
  logic                    out_valid;
  logic                    grant;
  logic                    flush_done;
  logic [PACKET_LEN-1:0]   masked_bits;
  logic [DATA_W-1:0]       word;

  // Clear every payload bit at or above the packet length. A shift by the
  // full width yields zero, so len == PACKET_LEN keeps every bit.
  assign masked_bits = packet_bits_i & ~({PACKET_LEN{1'b1}} << packet_len_i);

  // ---------------------------------------------------------------------------
  // Control: next state, output valid, pop/push sizes, grant
  // ---------------------------------------------------------------------------
  always_comb begin : ctrl
    fill_int   = int'(fill_q);
    n_bytes    = (int'(packet_len_i) + 7) / 8;
    state_d    = state_q;
    out_valid  = 1'b0;
    flush_done = 1'b0;
    grant      = 1'b0;
    pop_cnt    = 0;
    push_cnt   = 0;

    case (state_q)
      IDLE: begin
        out_valid = (fill_int >= LANES);
        if (flush_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // A partial word is offered while draining; flush_i is ignored here.
        out_valid = (fill_int > 0);
        if (fill_int == 0) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A partial (flush) pop takes whatever is left, so fill ends at zero.
    if (out_valid && ready_i) begin
      pop_cnt = (fill_int < LANES) ? fill_int : LANES;
    end

    // Space is judged after this cycle's pop so a full FIFO that is being
    // drained can still accept a packet.
    if ((state_q == IDLE) && valid_i &&
        ((DEPTH - fill_int + pop_cnt) >= (n_bytes + 1))) begin
      grant = 1'b1;
    end

    // Zero-length packets are consumed without adding a header byte.
    if (grant && (n_bytes > 0)) begin
      push_cnt = n_bytes + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO next contents: shift out popped bytes, append header and payload
  // ---------------------------------------------------------------------------
  always_comb begin : next_mem
    int base;
    int src;
    base  = fill_int - pop_cnt;
    src   = 0;
    mem_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src = i + pop_cnt;
      if (src < fill_int) begin
        mem_d[8*i +: 8] = mem_q[8*src +: 8];
      end else if ((push_cnt > 0) && (i == base)) begin
        mem_d[8*i +: 8] = 8'(n_bytes);
      end else if ((push_cnt > 0) && (i > base) && (i < base + push_cnt)) begin
        mem_d[8*i +: 8] = masked_bits[8*(i-base-1) +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word: lanes beyond the current fill read as zero, which gives the
  // zero upper lanes of a partial flush word.
  // ---------------------------------------------------------------------------
  always_comb begin : out_word
    word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l < fill_int) begin
        word[8*l +: 8] = mem_q[8*l +: 8];
      end
    end
  end

  assign data_o       = rst_i ? '0 : word;
  assign valid_o      = out_valid  & ~rst_i;
  assign grant_o      = grant      & ~rst_i;
  assign flush_done_o = flush_done & ~rst_i;
  assign state_o      = (state_q == FLUSH);
  assign fill_o       = fill_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fill_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= FILL_W'(fill_int - pop_cnt + push_cnt);
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_trdb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_trdb_stream_packer
//
// Bench for trdb_stream_packer with DATA_W=32, PACKET_LEN=64.
// Directed table of cycles from reset, hand-written multi-cycle sequences
// (backpressure until full, reset during a flush), then randomized cycles
// checked against a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_trdb_stream_packer;

  localparam int DATA_W     = 32;
  localparam int PACKET_LEN = 64;
  localparam int LEN_W      = 7;
  localparam int LANES      = 4;
  localparam int DEPTH      = 13;
  localparam int FILL_W     = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                  clk;
  logic                  rst;
  logic [PACKET_LEN-1:0] packet_bits;
  logic [LEN_W-1:0]      packet_len;
  logic                  valid;
  logic                  grant;
  logic [DATA_W-1:0]     data;
  logic                  out_valid;
  logic                  ready;
  logic                  flush;
  logic                  flush_done;
  logic                  state;
  logic [FILL_W-1:0]     fill;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trdb_stream_packer #(
    .DATA_W    (DATA_W),
    .PACKET_LEN(PACKET_LEN)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .packet_bits_i(packet_bits),
    .packet_len_i (packet_len),
    .valid_i      (valid),
    .grant_o      (grant),
    .data_o       (data),
    .valid_o      (out_valid),
    .ready_i      (ready),
    .flush_i      (flush),
    .flush_done_o (flush_done),
    .state_o      (state),
    .fill_o       (fill)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: reference byte stream and flush flag
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_q[$];
  bit          m_flush;
  logic        exp_grant;
  logic        exp_valid;
  logic        exp_done;
  logic [31:0] exp_data;
  int          exp_pop;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected outputs for the current inputs and reference contents.
  task automatic model_eval();
    int cnt;
    int n;
    cnt       = exp_q.size();
    n         = (int'(packet_len) + 7) / 8;
    exp_grant = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_data  = '0;
    exp_pop   = 0;
    if (!rst) begin
      exp_valid = m_flush ? (cnt > 0) : (cnt >= LANES);
      for (int l = 0; l < LANES; l++) begin
        if (l < cnt) exp_data[8*l +: 8] = exp_q[l];
      end
      if (exp_valid && ready) exp_pop = (cnt < LANES) ? cnt : LANES;
      exp_grant = !m_flush && valid && ((DEPTH - cnt + exp_pop) >= (n + 1));
      exp_done  = m_flush && (cnt == 0);
    end
  endtask

  // Advance the reference at the clock edge.
  task automatic model_commit();
    logic [63:0] masked;
    int          n;
    if (rst) begin
      exp_q.delete();
      m_flush = 1'b0;
    end else begin
      for (int k = 0; k < exp_pop; k++) void'(exp_q.pop_front());
      if (exp_grant && (packet_len != 0)) begin
        n      = (int'(packet_len) + 7) / 8;
        masked = packet_bits & ((64'd1 << packet_len) - 64'd1);
        exp_q.push_back(8'(n));
        for (int k = 0; k < n; k++) exp_q.push_back(masked[8*k +: 8]);
      end
      if (m_flush) begin
        if (exp_done) m_flush = 1'b0;
      end else if (flush) begin
        m_flush = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input bit r, input bit v, input int len,
                       input logic [63:0] b, input bit rdy, input bit fl);
    rst         = r;
    valid       = v;
    packet_len  = LEN_W'(len);
    packet_bits = b;
    ready       = rdy;
    flush       = fl;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".grant"}, 64'(grant), 64'(exp_grant));
    chk({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
    chk({tag, ".done"},  64'(flush_done), 64'(exp_done));
    chk({tag, ".fill"},  64'(fill), 64'(exp_q.size()));
    chk({tag, ".state"}, 64'(state), 64'(m_flush));
    if (exp_valid || rst) chk({tag, ".data"}, 64'(data), 64'(exp_data));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst;
    bit          valid;
    int          len;
    logic [63:0] bits;
    bit          ready;
    bit          flush;
    bit          e_grant;
    bit          e_valid;
    bit          chk_data;
    logic [31:0] e_data;
    bit          e_done;
    bit          chk_dbg;
    int          e_fill;
    bit          e_state;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int len, logic [63:0] b, bit rdy, bit fl,
                              bit eg, bit ev, bit cd, logic [31:0] ed, bit edn,
                              bit cdb, int ef, bit es);
    vec_t t;
    t.rst = r; t.valid = v; t.len = len; t.bits = b; t.ready = rdy; t.flush = fl;
    t.e_grant = eg; t.e_valid = ev; t.chk_data = cd; t.e_data = ed; t.e_done = edn;
    t.chk_dbg = cdb; t.e_fill = ef; t.e_state = es;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_flush = 1'b0;

    //            rst v len bits         rdy fl | gnt vld cd data          dn dbg fill st
    tbl[0]  = mk(1, 1, 24, 64'hCCBBAA, 1, 0,   0,  0,  1, 32'h0,        0, 0,  0,  0);
    tbl[1]  = mk(1, 1, 24, 64'hCCBBAA, 1, 0,   0,  0,  1, 32'h0,        0, 1,  0,  0);
    tbl[2]  = mk(0, 1, 24, 64'hCCBBAA, 1, 0,   1,  0,  0, 32'h0,        0, 1,  0,  0);
    tbl[3]  = mk(0, 0, 0,  64'h0,      1, 0,   0,  1,  1, 32'hCCBBAA03, 0, 1,  4,  0);
    tbl[4]  = mk(0, 0, 0,  64'h0,      1, 0,   0,  0,  0, 32'h0,        0, 1,  0,  0);
    tbl[5]  = mk(0, 1, 8,  64'h11,     1, 0,   1,  0,  0, 32'h0,        0, 1,  0,  0);
    tbl[6]  = mk(0, 1, 16, 64'h3322,   1, 0,   1,  0,  0, 32'h0,        0, 1,  2,  0);
    tbl[7]  = mk(0, 0, 0,  64'h0,      0, 0,   0,  1,  1, 32'h22021101, 0, 1,  5,  0);
    tbl[8]  = mk(0, 0, 0,  64'h0,      1, 0,   0,  1,  1, 32'h22021101, 0, 1,  5,  0);
    tbl[9]  = mk(0, 0, 0,  64'h0,      0, 1,   0,  0,  0, 32'h0,        0, 1,  1,  0);
    tbl[10] = mk(0, 0, 0,  64'h0,      1, 0,   0,  1,  1, 32'h00000033, 0, 1,  1,  1);
    tbl[11] = mk(0, 0, 0,  64'h0,      1, 0,   0,  0,  0, 32'h0,        1, 1,  0,  1);
    tbl[12] = mk(0, 0, 0,  64'h0,      1, 0,   0,  0,  0, 32'h0,        0, 1,  0,  0);
    tbl[13] = mk(0, 1, 0,  64'hFF,     1, 0,   1,  0,  0, 32'h0,        0, 1,  0,  0);
    tbl[14] = mk(0, 0, 0,  64'h0,      1, 0,   0,  0,  0, 32'h0,        0, 1,  0,  0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].len, tbl[i].bits, tbl[i].ready, tbl[i].flush);
      chk($sformatf("tbl%0d.grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("tbl%0d.valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.done", i),  64'(flush_done), 64'(tbl[i].e_done));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d.data", i), 64'(data), 64'(tbl[i].e_data));
      if (tbl[i].chk_dbg) begin
        chk($sformatf("tbl%0d.fill", i),  64'(fill), 64'(tbl[i].e_fill));
        chk($sformatf("tbl%0d.state", i), 64'(state), 64'(tbl[i].e_state));
      end
      tick();
    end

    // -------------------------------------------------------------------------
    // Masking and backpressure: len=4 bits=0xFF gives bytes 01 0F per packet.
    // With ready low the FIFO (13 bytes) takes six packets, then refuses.
    // -------------------------------------------------------------------------
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 4, 64'hFF, 0, 0);
      chk($sformatf("bp%0d.grant", i), 64'(grant), 64'(i < 6));
      chk($sformatf("bp%0d.fill", i),  64'(fill), 64'(2 * ((i < 6) ? i : 6)));
      chk($sformatf("bp%0d.valid", i), 64'(out_valid), 64'(i >= 2));
      if (i >= 2) chk($sformatf("bp%0d.data", i), 64'(data), 64'h0F010F01);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 64'h0, 1, 0);
      chk($sformatf("drain%0d.valid", j), 64'(out_valid), 64'(j < 3));
      chk($sformatf("drain%0d.fill", j),  64'(fill), 64'(12 - 4 * j));
      if (j < 3) chk($sformatf("drain%0d.data", j), 64'(data), 64'h0F010F01);
      tick();
    end

    // -------------------------------------------------------------------------
    // Reset in the middle of a flush: two bytes buffered, no ready.
    // -------------------------------------------------------------------------
    drive(0, 1, 8, 64'h5A, 0, 0);
    chk("rmf.grant", 64'(grant), 64'd1);
    tick();
    drive(0, 0, 0, 64'h0, 0, 1);
    chk("rmf.fill", 64'(fill), 64'd2);
    chk("rmf.valid_idle", 64'(out_valid), 64'd0);
    tick();
    drive(0, 0, 0, 64'h0, 0, 0);
    chk("rmf.state_flush", 64'(state), 64'd1);
    chk("rmf.valid_part", 64'(out_valid), 64'd1);
    chk("rmf.data_part", 64'(data), 64'h00005A01);
    tick();
    drive(1, 0, 0, 64'h0, 0, 0);
    chk("rmf.rst_valid", 64'(out_valid), 64'd0);
    chk("rmf.rst_data", 64'(data), 64'd0);
    chk("rmf.rst_done", 64'(flush_done), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 64'h0, 1, 0);
      chk($sformatf("rmf.post%0d.state", k), 64'(state), 64'd0);
      chk($sformatf("rmf.post%0d.valid", k), 64'(out_valid), 64'd0);
      chk($sformatf("rmf.post%0d.done", k),  64'(flush_done), 64'd0);
      chk($sformatf("rmf.post%0d.fill", k),  64'(fill), 64'd0);
      tick();
    end
    drive(0, 1, 24, 64'h030201, 1, 0);
    chk("rmf.new_grant", 64'(grant), 64'd1);
    tick();
    drive(0, 0, 0, 64'h0, 1, 0);
    chk("rmf.new_valid", 64'(out_valid), 64'd1);
    chk("rmf.new_data", 64'(data), 64'h03020103);
    tick();

    // -------------------------------------------------------------------------
    // Randomized cycles against the reference model
    // -------------------------------------------------------------------------
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, PACKET_LEN)),
            {$urandom, $urandom},
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 24) == 0));
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
